// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter in front of a single-port data RAM
// (asynchronous read, synchronous write). Port 0 is instruction fetch and
// port 1 is load/store. Each access takes one SERVE cycle. The acknowledge
// and read data are registered and appear in the cycle after SERVE.
//
// Optional build macro:
//   RAM_ARB_FIXED_PRIO_EN - when defined, port 0 always wins a contended
//                           decision and the round-robin 'last' pointer is
//                           removed. Port 1 can starve. When undefined
//                           (default), ties alternate round-robin.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no access in progress; RAM drive lines parked at zero
// SERVE0 | port 0 owns the RAM this cycle; ack0/rdata0 update at its end
// SERVE1 | port 1 owns the RAM this cycle; ack1/rdata1 update at its end

module ram_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic                  i_we0,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_data0,
  input  logic [DATA_WIDTH-1:0] i_data1,
  output logic                  o_ack0,
  output logic                  o_ack1,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_we,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SERVE0 = 2'd1,
    ST_SERVE1 = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  serve0, serve1;

`ifndef RAM_ARB_FIXED_PRIO_EN
  // Port served most recently. Reset value 1 makes port 0 win the first tie.
  logic                  last_q, last_d;
`endif

  assign serve0 = (state_q == ST_SERVE0);
  assign serve1 = (state_q == ST_SERVE1);

  // Next-state decision. The port being served is still holding its request
  // (it has not seen its ack yet), so only the other port's request counts
  // when leaving a SERVE state.
  always_comb begin
    state_d = ST_IDLE;
`ifndef RAM_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (i_req0 && i_req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
          state_d = ST_SERVE0;
`else
          state_d = last_q ? ST_SERVE0 : ST_SERVE1;
`endif
        end else if (i_req0) begin
          state_d = ST_SERVE0;
        end else if (i_req1) begin
          state_d = ST_SERVE1;
        end
      end
      ST_SERVE0: begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        // Port 0's request is still high here, so under fixed priority
        // port 1 only follows directly when port 0 is not asking.
        state_d = (i_req1 && !i_req0) ? ST_SERVE1 : ST_IDLE;
`else
        last_d  = 1'b0;
        state_d = i_req1 ? ST_SERVE1 : ST_IDLE;
`endif
      end
      ST_SERVE1: begin
`ifndef RAM_ARB_FIXED_PRIO_EN
        last_d  = 1'b1;
`endif
        state_d = i_req0 ? ST_SERVE0 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Completion pulse and read-data capture for the port served this cycle.
  // Writes leave the port's read data untouched.
  always_comb begin
    ack0_d   = serve0;
    ack1_d   = serve1;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (serve0 && !i_we0) rdata0_d = i_ram_rdata;
    if (serve1 && !i_we1) rdata1_d = i_ram_rdata;
  end

  // State, pointer, ack and read-data registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

`ifndef RAM_ARB_FIXED_PRIO_EN
  // Round-robin pointer register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // RAM drive multiplexer. Lines are parked at zero outside SERVE, and the
  // write enable is gated by reset so an access aborted by reset never
  // commits to the RAM.
  always_comb begin
    o_ram_addr = '0;
    o_ram_data = '0;
    o_ram_we   = 1'b0;
    if (serve0) begin
      o_ram_addr = i_addr0;
      o_ram_data = i_data0;
      o_ram_we   = i_we0 & i_rst_n;
    end else if (serve1) begin
      o_ram_addr = i_addr1;
      o_ram_data = i_data1;
      o_ram_we   = i_we1 & i_rst_n;
    end
  end

  assign o_ack0   = ack0_q;
  assign o_ack1   = ack1_q;
  assign o_rdata0 = rdata0_q;
  assign o_rdata1 = rdata1_q;
  assign o_busy   = serve0 | serve1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter. It contains a behavioural RAM and a
// transaction-level model. The model uses a shadow memory updated in ack
// order, latency rules, and per-port expected read data.
module tb_ram_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_rdata;
  logic          busy;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_data0(data0), .i_data1(data1),
    .o_ack0(ack0), .o_ack1(ack1), .o_rdata0(rdata0), .o_rdata1(rdata1),
    .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_data(ram_data),
    .i_ram_rdata(ram_rdata), .o_busy(busy)
  );

  // Behavioural single-port RAM: async read, write on posedge, preloaded
  // with a known pattern while mem_ready is low.
  logic [DW-1:0] mem [0:31];
  logic          mem_ready = 1'b0;
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_data;
    end
  end

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            act [2];
  int            issue [2];
  txn_t          cur [2];
  txn_t          q0 [$];
  txn_t          q1 [$];
  logic [DW-1:0] shadow [32];
  logic [DW-1:0] exp_rd [2];
  int            last_ack_cyc [2];
  int            last_lat [2];
  bit            prev_ack [2];
  logic          s_we, s_busy;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic we, input int addr, input logic [DW-1:0] data);
    txn_t t;
    t.we = we;
    t.addr = AW'(addr);
    t.data = data;
    return t;
  endfunction

  task automatic drive();
    req0 = act[0]; we0 = cur[0].we; addr0 = cur[0].addr; data0 = cur[0].data;
    req1 = act[1]; we1 = cur[1].we; addr1 = cur[1].addr; data1 = cur[1].data;
  endtask

  task automatic issue_new();
    if (!act[0] && q0.size() > 0) begin cur[0] = q0.pop_front(); act[0] = 1; issue[0] = cyc; end
    if (!act[1] && q1.size() > 0) begin cur[1] = q1.pop_front(); act[1] = 1; issue[1] = cyc; end
    drive();
  endtask

  // Sample the RAM lines mid-cycle, then advance to just after the next edge.
  task automatic tick();
    @(negedge clk);
    s_we = ram_we; s_addr = ram_addr; s_data = ram_data; s_busy = busy;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    bit a [2];
    int lat;
    logic [37:0] exp_lines;
    tick();
    a[0] = ack0;
    a[1] = ack1;
    chk("ack_exclusive", 64'(ack0 & ack1), 0);
    chk("busy_vs_serve", 64'(s_busy), 64'(a[0] | a[1]));
    if (!(a[0] || a[1])) chk("ram_idle_lines", 64'({s_we, s_addr, s_data}), 0);
    for (int k = 0; k < 2; k++) begin
      if (a[k]) begin
        chk("ack_consecutive", 64'(prev_ack[k]), 0);
        chk("ack_unsolicited", 64'(act[k]), 1);
        if (act[k]) begin
          lat = cyc - issue[k];
          chk("ack_latency", 64'(lat == 2 || (lat == 3 && last_ack_cyc[1-k] == cyc - 1)), 1);
          exp_lines = {cur[k].we, cur[k].addr, (cur[k].we ? cur[k].data : 32'h0)};
          chk("serve_lines", 64'({s_we, s_addr, (s_we ? s_data : 32'h0)}), 64'(exp_lines));
          if (cur[k].we) shadow[cur[k].addr] = cur[k].data;
          else exp_rd[k] = shadow[cur[k].addr];
          act[k] = 0;
          last_lat[k] = lat;
          last_ack_cyc[k] = cyc;
        end
      end else if (act[k]) begin
        chk("ack_timeout", 64'(cyc - issue[k] < 3), 1);
      end
      prev_ack[k] = a[k];
    end
    chk("rdata0", 64'(rdata0), 64'(exp_rd[0]));
    chk("rdata1", 64'(rdata1), 64'(exp_rd[1]));
    issue_new();
  endtask

  task automatic run_idle();
    issue_new();
    for (int i = 0; i < 200 && (act[0] || act[1] || q0.size() > 0 || q1.size() > 0); i++) step();
    chk("drain_timeout", 64'(act[0] || act[1] || q0.size() > 0 || q1.size() > 0), 0);
  endtask

  // Reset for two cycles with both ports requesting writes.
  task automatic do_reset();
    rst_n = 0;
    act[0] = 0; act[1] = 0;
    q0.delete(); q1.delete();
    req0 = 1; req1 = 1; we0 = 1; we1 = 1;
    addr0 = 5'd7; addr1 = 5'd8; data0 = 32'hDEAD; data1 = 32'hBEEF;
    tick();
    tick();
    chk("rst_ack0", 64'(ack0), 0);
    chk("rst_ack1", 64'(ack1), 0);
    chk("rst_rdata0", 64'(rdata0), 0);
    chk("rst_rdata1", 64'(rdata1), 0);
    chk("rst_ram_we", 64'({ram_we, s_we}), 0);
    chk("rst_ram_addr_data", 64'({ram_addr, ram_data}), 0);
    chk("rst_busy", 64'(busy), 0);
    exp_rd[0] = '0; exp_rd[1] = '0;
    prev_ack[0] = 0; prev_ack[1] = 0;
    last_ack_cyc[0] = -10; last_ack_cyc[1] = -10;
    mem_ready = 1'b1;
    rst_n = 1;
    req0 = 0; req1 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, first, lastc, gaps;
    for (int i = 0; i < 32; i++) shadow[i] = 32'hA5A5_0000 | 32'(i);
    cur[0] = '0; cur[1] = '0;
    act[0] = 0; act[1] = 0;
    rst_n = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;

    // Reset, then both ports tie: port 0 must be served first.
    do_reset();
    q0.push_back(mk(1, 5, 32'h0000_0505));
    q1.push_back(mk(1, 6, 32'h0000_0606));
    issue_new();
    step();
    chk("first_serve_port0", 64'({busy, ram_addr}), 64'({1'b1, 5'd5}));
    run_idle();
    chk("tie_lat0", 64'(last_lat[0]), 2);
    chk("tie_lat1", 64'(last_lat[1]), 3);

    // Port 1 single write then read back.
    q1.push_back(mk(1, 3, 32'd244));
    issue_new();
    chk("wr_we_cycle0", 64'(ram_we), 0);
    step();
    chk("wr_we_cycle1", 64'({ram_we, ram_addr, ram_data}), 64'({1'b1, 5'd3, 32'd244}));
    step();
    chk("wr_ack1_cycle2", 64'({ack1, ram_we}), 64'({1'b1, 1'b0}));
    q1.push_back(mk(0, 3, 0));
    run_idle();
    chk("rd_port1_244", 64'(rdata1), 244);

    // Simultaneous from IDLE after reset.
    do_reset();
    q0.push_back(mk(0, 3, 0));
    q1.push_back(mk(1, 1, 32'd140));
    run_idle();
    chk("sim_lat0", 64'(last_lat[0]), 2);
    chk("sim_lat1", 64'(last_lat[1]), 3);
    chk("sim_rdata0", 64'(rdata0), 244);
    q0.push_back(mk(0, 1, 0));
    run_idle();
    chk("sim_readback_140", 64'(rdata0), 140);

    // Both ports continuously re-requesting: acks alternate with no gaps.
    for (int i = 0; i < 8; i++) begin
      q0.push_back(mk(0, int'($urandom_range(0, 31)), 0));
      q1.push_back(mk(0, int'($urandom_range(0, 31)), 0));
    end
    issue_new();
    n0 = 0; n1 = 0; first = -1; lastc = -1; gaps = 0;
    for (int i = 0; i < 60 && (n0 + n1) < 16; i++) begin
      step();
      if (ack0 || ack1) begin
        if (first >= 0 && lastc != cyc - 1) gaps++;
        if (first < 0) first = cyc;
        lastc = cyc;
      end
      if (ack0) n0++;
      if (ack1) n1++;
    end
    chk("cont_acks0", 64'(n0), 8);
    chk("cont_acks1", 64'(n1), 8);
    chk("cont_gaps", 64'(gaps), 0);
    run_idle();

    // Reset during SERVE1 write: no ack and the write is suppressed.
    q0.push_back(mk(1, 2, 32'h55));
    run_idle();
    q1.push_back(mk(1, 2, 32'd77));
    issue_new();
    step();
    chk("abort_serve1", 64'({busy, ram_we}), 64'({1'b1, 1'b1}));
    rst_n = 0;
    #1;
    chk("abort_we_gated", 64'(ram_we), 0);
    tick();
    chk("abort_no_ack1", 64'({ack1, busy}), 0);
    do_reset();
    q0.push_back(mk(0, 2, 0));
    run_idle();
    chk("abort_old_value", 64'(rdata0), 32'h55);

    // Port 0 read followed by port 1 write of the same address.
    q1.push_back(mk(1, 9, 32'h11));
    run_idle();
    do_reset();
    q0.push_back(mk(0, 9, 0));
    q1.push_back(mk(1, 9, 32'h99));
    run_idle();
    chk("raw_port0_old", 64'(rdata0), 32'h11);
    q1.push_back(mk(0, 9, 0));
    run_idle();
    chk("raw_port1_new", 64'(rdata1), 32'h99);

    // Randomized traffic on a small address window.
    issue_new();
    for (int i = 0; i < 400; i++) begin
      if (q0.size() == 0 && $urandom_range(0, 2) != 0)
        q0.push_back(mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom));
      if (q1.size() == 0 && $urandom_range(0, 2) != 0)
        q1.push_back(mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom));
      step();
    end
    run_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares the single-port data RAM (`ram`: asynchronous read, write on `posedge i_clk`) between the instruction-fetch port (port 0) and the load/store port (port 1). It serializes accesses, drives the RAM address, write-enable and write-data lines, and returns registered read data with a one-cycle acknowledge pulse per requester. The block sits between the MIPS core's fetch/memory stages and the `ram` instance.

## Interface

- `ADDR_WIDTH`, 5: RAM word-address width.
- `DATA_WIDTH`, 32: RAM data width.

- `i_clk`  in  1  system clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_req0`, `i_req1`  in  1 each  access request; held high until the matching ack.
- `i_we0`, `i_we1`  in  1 each  1 = write, 0 = read; stable while the request is held.
- `i_addr0`, `i_addr1`  in  ADDR_WIDTH each  word address; stable while the request is held.
- `i_data0`, `i_data1`  in  DATA_WIDTH each  write data; stable while the request is held.
- `o_ack0`, `o_ack1`  out  1 each  one-cycle completion pulse, registered.
- `o_rdata0`, `o_rdata1`  out  DATA_WIDTH each  registered read data; valid when the matching ack is high, held until the next read completes on that port.
- `o_ram_addr`  out  ADDR_WIDTH  to RAM `i_addr`.
- `o_ram_we`  out  1  to RAM `i_we`.
- `o_ram_data`  out  DATA_WIDTH  to RAM `i_data`.
- `i_ram_rdata`  in  DATA_WIDTH  from RAM `o_data`.
- `o_busy`  out  1  high while in a SERVE state.

## Operation

- FSM states: IDLE, SERVE0, SERVE1. Exactly one requester is served per SERVE cycle.
- IDLE:
  - No request: stay in IDLE.
  - One request: go to SERVE of that port.
  - Both requests: go to SERVE of the port that is not `last` (round-robin).
- SERVE_k (one cycle):
  - `o_ram_addr = i_addr_k`, `o_ram_data = i_data_k`, `o_ram_we = i_we_k`. The RAM write commits at the edge that ends the cycle.
  - At that edge: `o_ack_k <= 1`; if `!i_we_k`, `o_rdata_k <= i_ram_rdata`; `last <= k`.
  - Next state: SERVE of the other port if its request is high, else IDLE.
  - Requester k's own request is ignored at this edge, because it has not yet seen its ack.
- A requester that keeps `i_req_k` high in the ack cycle is issuing a new request. It is arbitrated normally from that cycle on.
- Outside SERVE: `o_ram_we = 0`, `o_ram_addr = 0`, `o_ram_data = 0` (no spurious writes).
- `o_ack_k` is never high for two consecutive cycles. `o_ack0` and `o_ack1` are never high in the same cycle.
- A write does not update `o_rdata_k`.

## Timing

- Reset (`i_rst_n = 0` at a rising edge):
  - State → IDLE, `last` → 1, so port 0 wins the first tie.
  - `o_ack0 = o_ack1 = 0`, `o_rdata0 = o_rdata1 = 0`, `o_busy = 0`, RAM drive lines 0.
- Reset mid-SERVE: the access is aborted and no ack is issued. The RAM write in that cycle is suppressed because `o_ram_we` is gated by `i_rst_n`.
- Uncontended latency: request seen in cycle 0 (IDLE) → SERVE in cycle 1 → ack high in cycle 2.
- Contended case: the loser is served in the cycle immediately after the winner's SERVE cycle. Its ack arrives one cycle after the winner's ack.
- Both ports continuously requesting: SERVE0 and SERVE1 alternate every cycle, giving 100% RAM utilization.
- Read data is captured from the asynchronous RAM read in the SERVE cycle. Read-after-write to the same address from the other port in the next SERVE returns the new data.

## Configuration

- `RAM_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority; port 0 always wins when both are requesting (including from SERVE1 → next decision), and `last` is unused. Port 1 can starve while port 0 continuously re-requests.
  - Undefined (default): round-robin as described above.

## Test plan

- Reset: hold `i_rst_n = 0` for 2 cycles with both requests high → acks 0, rdata 0, `o_ram_we = 0`, state IDLE. First SERVE after release is SERVE0.
- Single write then read, port 1: write `addr = 3`, `data = 244` → `o_ack1` in cycle 2 and `o_ram_we` high only in cycle 1. Then read `addr = 3` → `o_rdata1 = 244` with `o_ack1`.
- Simultaneous requests from IDLE after reset: port 0 reads addr 3, port 1 writes addr 1 = 140 → `o_ack0` in cycle 2, `o_ack1` in cycle 3, `o_rdata0 = 244`. A subsequent read of addr 1 returns 140.
- Both ports continuously re-requesting for 8 cycles → acks alternate 0,1,0,1… with no idle cycles and no simultaneous acks. Under `RAM_ARB_FIXED_PRIO_EN`, only `o_ack0` pulses, every other cycle.
- Reset asserted during SERVE1 with a write of 77 to addr 2 → no `o_ack1`, and a later read of addr 2 returns the old value.
- Port 0 read in flight while port 1 writes the same address in the following SERVE → `o_rdata0` holds the old value and port 1's next read returns the new value.
